led_sched: RTL and testbench

Scheduler that owns the front-panel LED bank of the desk clock and shares it among three requesters: the free-running display pattern (off, rotate-left, rotate-right/ping-pong, static), a one-shot event flash, and the alarm blink. The block sits between the clock/alarm/key logic and the LED pins. It contains a fixed-priority arbiter (alarm > event > pattern), the step and blink dividers, and a registered LED output.

---
 rtl/led_sched.sv | 158 +++++++++++++++
 tb/tb_led_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sched.sv
// Front-panel LED scheduler: fixed-priority arbitration of alarm blink, event flash and pattern.
// Define LED_SCHED_PINGPONG_EN to make mode 2 bounce instead of rotating right.
module led_sched #(
  parameter int unsigned         CLK_DIV     = 50_000_000 / 4 - 1,
  parameter int unsigned         BLINK_DIV   = 50_000_000 / 8 - 1,
  parameter int unsigned         LED_NUM     = 4,
  parameter logic [LED_NUM-1:0]  ROT_INIT    = LED_NUM'(1),
  parameter int unsigned         FLASH_STEPS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [LED_NUM-1:0] static_pat,
  input  logic               evt_req,
  input  logic [LED_NUM-1:0] evt_pat,
  input  logic               alarm_req,
  output logic               alarm_ack,
  output logic               busy,
  output logic [LED_NUM-1:0] led
);

  localparam int unsigned CW = $clog2(CLK_DIV) + 1;
  localparam int unsigned BW = $clog2(BLINK_DIV) + 1;
  localparam int unsigned EW = $clog2(FLASH_STEPS) + 1;

  typedef enum logic [1:0] {
    StNorm = 2'd0,
    StEvt  = 2'd1,
    StAlm  = 2'd2
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [BW-1:0]      blink_cnt_q;
  logic [EW-1:0]      evt_cnt_q;
  logic               blink_q;
  logic [LED_NUM-1:0] rot_q;
  logic [LED_NUM-1:0] evt_pat_q;
  logic [1:0]         mode_q;
`ifdef LED_SCHED_PINGPONG_EN
  logic               dir_q;  // 0 = left, 1 = right
`endif

  logic               tick;
  logic [LED_NUM-1:0] rot_l;
  logic [LED_NUM-1:0] rot_r;

  assign tick  = (cnt_q == CW'(CLK_DIV));
  assign rot_l = {rot_q[LED_NUM-2:0], rot_q[LED_NUM-1]};
  assign rot_r = {rot_q[0], rot_q[LED_NUM-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StNorm;
      cnt_q       <= '0;
      blink_cnt_q <= '0;
      evt_cnt_q   <= '0;
      blink_q     <= 1'b0;
      rot_q       <= ROT_INIT;
      evt_pat_q   <= '0;
      mode_q      <= 2'd0;
`ifdef LED_SCHED_PINGPONG_EN
      dir_q       <= 1'b0;
`endif
      alarm_ack   <= 1'b0;
      busy        <= 1'b0;
      led         <= '0;
    end else begin
      mode_q <= mode;
      cnt_q  <= tick ? '0 : cnt_q + CW'(1);

      if (alarm_req) begin
        state_q <= StAlm;
        if (state_q != StAlm) begin
          blink_q     <= 1'b1;
          blink_cnt_q <= '0;
        end else if (blink_cnt_q == BW'(BLINK_DIV)) begin
          blink_q     <= ~blink_q;
          blink_cnt_q <= '0;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end else begin
        unique case (state_q)
          StNorm: begin
            if (evt_req) begin
              state_q   <= StEvt;
              evt_pat_q <= evt_pat;
              cnt_q     <= '0;  // restart the divider so the flash lasts exactly FLASH_STEPS ticks
              evt_cnt_q <= '0;
            end
          end
          StEvt: begin
            if (tick) begin
              if (evt_cnt_q == EW'(FLASH_STEPS - 1)) begin
                state_q <= StNorm;
              end else begin
                evt_cnt_q <= evt_cnt_q + EW'(1);
              end
            end
          end
          StAlm:   state_q <= StNorm;
          default: state_q <= StNorm;
        endcase
      end

      // A mode change reloads the rotator and beats a coincident tick.
      if (mode != mode_q) begin
        rot_q <= ROT_INIT;
`ifdef LED_SCHED_PINGPONG_EN
        dir_q <= 1'b0;
`endif
      end else if (state_q == StNorm && tick) begin
        case (mode_q)
          2'd1: rot_q <= rot_l;
          2'd2: begin
`ifdef LED_SCHED_PINGPONG_EN
            if (!dir_q) begin
              if (rot_q[LED_NUM-1]) begin
                dir_q <= 1'b1;
                rot_q <= rot_r;
              end else begin
                rot_q <= rot_l;
              end
            end else begin
              if (rot_q[0]) begin
                dir_q <= 1'b0;
                rot_q <= rot_l;
              end else begin
                rot_q <= rot_r;
              end
            end
`else
            rot_q <= rot_r;
`endif
          end
          default: ;
        endcase
      end

      alarm_ack <= (state_q == StAlm);
      busy      <= (state_q != StNorm);
      unique case (state_q)
        StNorm: begin
          case (mode_q)
            2'd0:    led <= '0;
            2'd3:    led <= static_pat;
            default: led <= rot_q;
          endcase
        end
        StEvt:   led <= evt_pat_q;
        StAlm:   led <= {LED_NUM{blink_q}};
        default: led <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sched.sv
// Directed self-checking bench for led_sched (CLK_DIV=3, BLINK_DIV=1, FLASH_STEPS=2, LED_NUM=4).
module tb_led_sched;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [3:0] static_pat;
  logic       evt_req;
  logic [3:0] evt_pat;
  logic       alarm_req;
  logic       alarm_ack;
  logic       busy;
  logic [3:0] led;

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  led_sched #(
    .CLK_DIV    (3),
    .BLINK_DIV  (1),
    .LED_NUM    (4),
    .ROT_INIT   (4'b0001),
    .FLASH_STEPS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .static_pat(static_pat),
    .evt_req   (evt_req),
    .evt_pat   (evt_pat),
    .alarm_req (alarm_req),
    .alarm_ack (alarm_ack),
    .busy      (busy),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges are counted from reset release; ticks fall on edges 4, 8, 12, ...
  task automatic goto(input int e);
    while (ecount < e) begin
      @(posedge clk);
      ecount++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    mode       = 2'd0;
    static_pat = 4'b0000;
    evt_req    = 1'b0;
    evt_pat    = 4'b0000;
    alarm_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    ecount = 0;
  endtask

  task automatic test_reset();
    do_reset();
    mode = 2'd3;
    static_pat = 4'b1111;
    goto(3);
    rst = 1'b0;
    #1;
    tests++;
    if (led !== 4'b0000) begin
      fails++; $display("FAIL reset_led: got %b want %b", led, 4'b0000);
    end
    tests++;
    if (busy !== 1'b0 || alarm_ack !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got busy=%b ack=%b want 0 0", busy, alarm_ack);
    end
    tests++;
    if (dut.rot_q !== 4'b0001) begin
      fails++; $display("FAIL reset_rot: got %b want %b", dut.rot_q, 4'b0001);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    mode = 2'd1;
    goto(1);
    tests++;
    if (led !== 4'b0000) begin
      fails++; $display("FAIL rot_e1: got %b want %b", led, 4'b0000);
    end
    goto(2);
    tests++;
    if (led !== 4'b0001) begin
      fails++; $display("FAIL rot_e2: got %b want %b", led, 4'b0001);
    end
    goto(4);
    tests++;
    if (led !== 4'b0001) begin
      fails++; $display("FAIL rot_e4: got %b want %b", led, 4'b0001);
    end
    for (int i = 0; i < 4; i++) begin
      goto(5 + 4 * i);
      tests++;
      if (led !== exp_seq[i]) begin
        fails++; $display("FAIL rot_step%0d: got %b want %b", i, led, exp_seq[i]);
      end
    end
  endtask

  task automatic test_static();
    do_reset();
    mode = 2'd3;
    static_pat = 4'b1010;
    goto(1);
    tests++;
    if (led !== 4'b0000) begin
      fails++; $display("FAIL static_e1: got %b want %b", led, 4'b0000);
    end
    goto(2);
    tests++;
    if (led !== 4'b1010) begin
      fails++; $display("FAIL static_e2: got %b want %b", led, 4'b1010);
    end
    mode = 2'd0;
    goto(3);
    tests++;
    if (led !== 4'b1010) begin
      fails++; $display("FAIL off_e3: got %b want %b", led, 4'b1010);
    end
    goto(4);
    tests++;
    if (led !== 4'b0000) begin
      fails++; $display("FAIL off_e4: got %b want %b", led, 4'b0000);
    end
  endtask

  task automatic test_event();
    do_reset();
    mode = 2'd1;
    goto(5);
    tests++;
    if (led !== 4'b0010) begin
      fails++; $display("FAIL evt_pre: got %b want %b", led, 4'b0010);
    end
    evt_req = 1'b1;
    evt_pat = 4'b0110;
    goto(6);
    evt_req = 1'b0;
    evt_pat = 4'b0000;
    tests++;
    if (led !== 4'b0010 || busy !== 1'b0) begin
      fails++; $display("FAIL evt_entry: got led=%b busy=%b want 0010 0", led, busy);
    end
    for (int e = 7; e <= 14; e++) begin
      goto(e);
      tests++;
      if (led !== 4'b0110 || busy !== 1'b1) begin
        fails++; $display("FAIL evt_e%0d: got led=%b busy=%b want 0110 1", e, led, busy);
      end
    end
    goto(15);
    tests++;
    if (led !== 4'b0010 || busy !== 1'b0) begin
      fails++; $display("FAIL evt_exit: got led=%b busy=%b want 0010 0", led, busy);
    end
    goto(19);
    tests++;
    if (led !== 4'b0100) begin
      fails++; $display("FAIL evt_resume: got %b want %b", led, 4'b0100);
    end
  endtask

  task automatic test_alarm_abort();
    logic [3:0] exp_blk [5] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111};
    do_reset();
    mode = 2'd1;
    evt_req = 1'b1;
    evt_pat = 4'b0110;
    goto(1);
    evt_req = 1'b0;
    goto(2);
    tests++;
    if (led !== 4'b0110 || busy !== 1'b1 || alarm_ack !== 1'b0) begin
      fails++; $display("FAIL abort_evt: got led=%b busy=%b ack=%b want 0110 1 0", led, busy,
                        alarm_ack);
    end
    goto(3);
    alarm_req = 1'b1;
    goto(4);
    tests++;
    if (alarm_ack !== 1'b0 || led !== 4'b0110) begin
      fails++; $display("FAIL abort_e4: got ack=%b led=%b want 0 0110", alarm_ack, led);
    end
    for (int i = 0; i < 5; i++) begin
      goto(5 + i);
      tests++;
      if (led !== exp_blk[i] || alarm_ack !== 1'b1 || busy !== 1'b1) begin
        fails++; $display("FAIL blink_e%0d: got led=%b ack=%b busy=%b want %b 1 1", 5 + i, led,
                          alarm_ack, busy, exp_blk[i]);
      end
    end
    alarm_req = 1'b0;
    goto(11);
    tests++;
    if (led !== 4'b0001 || alarm_ack !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL alarm_exit: got led=%b ack=%b busy=%b want 0001 0 0", led,
                        alarm_ack, busy);
    end
    goto(14);
    tests++;
    if (led !== 4'b0010 || busy !== 1'b0) begin
      fails++; $display("FAIL no_replay: got led=%b busy=%b want 0010 0", led, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_req = 1'b1;
    alarm_req = 1'b1;
    evt_pat = 4'b0110;
    goto(1);
    evt_req = 1'b0;
    goto(2);
    tests++;
    if (led !== 4'b1111 || busy !== 1'b1 || alarm_ack !== 1'b1) begin
      fails++; $display("FAIL simul_alm: got led=%b busy=%b ack=%b want 1111 1 1", led, busy,
                        alarm_ack);
    end
    evt_req = 1'b1;
    goto(3);
    evt_req = 1'b0;
    tests++;
    if (led !== 4'b1111 || busy !== 1'b1 || alarm_ack !== 1'b1) begin
      fails++; $display("FAIL evt_in_alm: got led=%b busy=%b ack=%b want 1111 1 1", led, busy,
                        alarm_ack);
    end
    alarm_req = 1'b0;
    for (int e = 5; e <= 8; e++) begin
      goto(e);
      tests++;
      if (led !== 4'b0000 || busy !== 1'b0 || alarm_ack !== 1'b0) begin
        fails++; $display("FAIL no_evt_e%0d: got led=%b busy=%b ack=%b want 0000 0 0", e, led,
                          busy, alarm_ack);
      end
    end
  endtask

  task automatic test_mode_tick();
    logic [3:0] exp_after;
`ifdef LED_SCHED_PINGPONG_EN
    exp_after = 4'b0010;
`else
    exp_after = 4'b1000;
`endif
    do_reset();
    mode = 2'd1;
    goto(7);
    mode = 2'd2;
    goto(9);
    tests++;
    if (led !== 4'b0001) begin
      fails++; $display("FAIL reload_wins: got %b want %b", led, 4'b0001);
    end
    goto(13);
    tests++;
    if (led !== exp_after) begin
      fails++; $display("FAIL reload_next: got %b want %b", led, exp_after);
    end
  endtask

  task automatic test_mode2();
`ifdef LED_SCHED_PINGPONG_EN
    logic [3:0] exp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
`else
    logic [3:0] exp_seq [7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
`endif
    do_reset();
    mode = 2'd2;
    goto(2);
    tests++;
    if (led !== 4'b0001) begin
      fails++; $display("FAIL mode2_e2: got %b want %b", led, 4'b0001);
    end
    for (int i = 0; i < 7; i++) begin
      goto(5 + 4 * i);
      tests++;
      if (led !== exp_seq[i]) begin
        fails++; $display("FAIL mode2_step%0d: got %b want %b", i, led, exp_seq[i]);
      end
    end
    rst = 1'b0;
    #1;
    tests++;
    if (led !== 4'b0000 || dut.rot_q !== 4'b0001) begin
      fails++; $display("FAIL mid_reset: got led=%b rot=%b want 0000 0001", led, dut.rot_q);
    end
  endtask

  initial begin
    rst        = 1'b0;
    mode       = 2'd0;
    static_pat = 4'b0000;
    evt_req    = 1'b0;
    evt_pat    = 4'b0000;
    alarm_req  = 1'b0;
    test_reset();
    test_rotate();
    test_static();
    test_event();
    test_alarm_abort();
    test_back_to_back();
    test_mode_tick();
    test_mode2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
